// File: rtl/neokeon_dec_rc_xor.sv
// -----------------------------------------------------------------------------
// neokeon_dec_rc_xor
//
// Round-constant stage for the decryption side of the Neokeon-128 core.
// The 8-bit round constant is walked backwards through the Neokeon LFSR
// sequence (0xD4, 0x6A, 0x35, ... 0x80 for the default parameters). The
// current constant is XORed into word a0 of each 128-bit state beat. Each
// block is NR+1 beats long. Results are held in a one-entry output register.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   s_valid    in   1    input beat valid
//   s_ready    out  1    input beat accepted when s_valid && s_ready
//   s_state    in   128  input state {a0,a1,a2,a3}; a0 = [127:96]
//   s_first    in   1    first beat of a block (sampled with s_valid)
//   m_valid    out  1    output beat valid
//   m_ready    in   1    downstream ready
//   m_state    out  128  state with the round constant applied to a0
//   m_rc       out  8    constant applied to the current m_state beat
//   m_last     out  1    current beat used the final constant
//   proto_err  out  1    only when NEOKEON_DEC_PROTOCOL_CHECK_EN is defined:
//                        sticky flag for a mid-block restart, or for a block
//                        that starts without s_first
//
// Optional build macro: NEOKEON_DEC_PROTOCOL_CHECK_EN
// -----------------------------------------------------------------------------
module neokeon_dec_rc_xor #(
    parameter int          NR      = 16,
    parameter logic [7:0]  RC_LAST = 8'hD4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [127:0]  s_state,
    input  logic          s_first,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [127:0]  m_state,
    output logic [7:0]    m_rc,
    output logic          m_last
`ifdef NEOKEON_DEC_PROTOCOL_CHECK_EN
    ,
    output logic          proto_err
`endif
);

    // The beat counter must be able to hold NR.
    localparam int CW = (NR < 1) ? 1 : $clog2(NR + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q,   state_d;
    logic [7:0]    rc_cur_q,  rc_cur_d;
    logic [CW-1:0] rnd_cnt_q, rnd_cnt_d;
    logic          m_valid_q, m_valid_d;
    logic [127:0]  m_state_q, m_state_d;
    logic [7:0]    m_rc_q,    m_rc_d;
    logic          m_last_q,  m_last_d;

    logic          accept;
    logic          blk_start;
    logic [7:0]    rc_use;
    logic [7:0]    rc_prev;
    logic [CW-1:0] beat_idx;
    logic          beat_last;

    // The output register may be refilled in the same cycle it drains.
    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;

    always_comb begin
        // A beat opens a block when nothing is in progress, or when
        // s_first forces a restart in the middle of a block.
        blk_start = (state_q == ST_IDLE) || s_first;
        rc_use    = blk_start ? RC_LAST : rc_cur_q;
        beat_idx  = blk_start ? '0 : rnd_cnt_q;
        beat_last = (beat_idx == CW'(NR));

        // Inverse of the forward step rc' = (rc << 1) ^ (rc[7] ? 0x1B : 0).
        // An odd constant can only come from a byte whose MSB was set.
        if (rc_use[0]) begin
            rc_prev = ((rc_use ^ 8'h1B) >> 1) | 8'h80;
        end else begin
            rc_prev = rc_use >> 1;
        end

        state_d   = state_q;
        rc_cur_d  = rc_cur_q;
        rnd_cnt_d = rnd_cnt_q;
        m_valid_d = m_valid_q && !m_ready;
        m_state_d = m_state_q;
        m_rc_d    = m_rc_q;
        m_last_d  = m_last_q;

        if (accept) begin
            m_valid_d = 1'b1;
            m_state_d = {s_state[127:96] ^ {24'h0, rc_use}, s_state[95:0]};
            m_rc_d    = rc_use;
            m_last_d  = beat_last;
            if (beat_last) begin
                state_d   = ST_IDLE;
                rc_cur_d  = RC_LAST;
                rnd_cnt_d = '0;
            end else begin
                state_d   = ST_RUN;
                rc_cur_d  = rc_prev;
                rnd_cnt_d = beat_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rc_cur_q  <= RC_LAST;
            rnd_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_state_q <= '0;
            m_rc_q    <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_cur_q  <= rc_cur_d;
            rnd_cnt_q <= rnd_cnt_d;
            m_valid_q <= m_valid_d;
            m_state_q <= m_state_d;
            m_rc_q    <= m_rc_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_state = m_state_q;
    assign m_rc    = m_rc_q;
    assign m_last  = m_last_q;

`ifdef NEOKEON_DEC_PROTOCOL_CHECK_EN
    logic proto_err_q, proto_err_d;

    always_comb begin
        proto_err_d = proto_err_q;
        if (accept) begin
            if ((state_q == ST_RUN && s_first) || (state_q == ST_IDLE && !s_first)) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_neokeon_dec_rc_xor.sv
// -----------------------------------------------------------------------------
// tb_neokeon_dec_rc_xor
//
// Testbench for neokeon_dec_rc_xor. It runs a set of directed scenarios and
// then randomized traffic. The reference model rebuilds the encrypt-side
// constant table with the forward Neokeon LFSR and reads it in reverse order.
// It tracks in-flight beats in a queue. Every check goes through check_eq.
// -----------------------------------------------------------------------------
module tb_neokeon_dec_rc_xor;

    localparam int NR = 16;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_state;
    logic         s_first;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_state;
    logic [7:0]   m_rc;
    logic         m_last;
`ifdef NEOKEON_DEC_PROTOCOL_CHECK_EN
    logic         proto_err;
`endif

    neokeon_dec_rc_xor #(.NR(NR), .RC_LAST(8'hD4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_state   (s_state),
        .s_first   (s_first),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_state   (m_state),
        .m_rc      (m_rc),
        .m_last    (m_last)
`ifdef NEOKEON_DEC_PROTOCOL_CHECK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [127:0] state;
        logic [7:0]   rc;
        logic         last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] enc_rc [0:NR];   // encrypt order: enc_rc[0] = 0x80
    bit         in_block;
    int         beat_k;
    bit         exp_perr;
    int         acc_cnt;
    int         xfer_cnt;

    initial begin
        enc_rc[0] = 8'h80;
        for (int i = 1; i <= NR; i++) begin
            enc_rc[i] = {enc_rc[i-1][6:0], 1'b0} ^ (enc_rc[i-1][7] ? 8'h1B : 8'h00);
        end
    end

    task automatic model_reset();
        exp_q.delete();
        in_block = 1'b0;
        beat_k   = 0;
        exp_perr = 1'b0;
    endtask

    // Scoreboard: everything is sampled on the falling edge. Inputs are
    // then stable for the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            bit    exp_mv;
            bit    exp_sr;
            int    k;
            beat_t b;
            exp_mv = (exp_q.size() != 0);
            exp_sr = !exp_mv || m_ready;
            check_eq("m_valid", m_valid, exp_mv);
            check_eq("s_ready", s_ready, exp_sr);
`ifdef NEOKEON_DEC_PROTOCOL_CHECK_EN
            check_eq("proto_err", proto_err, exp_perr);
`endif
            if (exp_mv) begin
                check_eq("m_state", m_state, exp_q[0].state);
                check_eq("m_rc", m_rc, exp_q[0].rc);
                check_eq("m_last", m_last, exp_q[0].last);
                if (m_ready) begin
                    $display("[TB] out beat rc=%h last=%0d state=%h", exp_q[0].rc, exp_q[0].last, exp_q[0].state);
                    exp_q.delete(0);
                    xfer_cnt++;
                end
            end
            if (s_valid && exp_sr) begin
                if ((in_block && s_first) || (!in_block && !s_first)) exp_perr = 1'b1;
                k       = (in_block && !s_first) ? beat_k : 0;
                b.rc    = enc_rc[NR-k];
                b.state = {s_state[127:96] ^ {24'h0, b.rc}, s_state[95:0]};
                b.last  = (k == NR);
                exp_q.push_back(b);
                acc_cnt++;
                if (k == NR) begin
                    in_block = 1'b0;
                    beat_k   = 0;
                end else begin
                    in_block = 1'b1;
                    beat_k   = k + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic sv, input logic sf, input logic [127:0] st, input logic mr);
        s_valid = sv;
        s_first = sf;
        s_state = st;
        m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_m_valid"}, m_valid, 1'b0);
        check_eq({tag, "_m_state"}, m_state, 128'h0);
        check_eq({tag, "_m_rc"}, m_rc, 8'h00);
        check_eq({tag, "_m_last"}, m_last, 1'b0);
`ifdef NEOKEON_DEC_PROTOCOL_CHECK_EN
        check_eq({tag, "_proto_err"}, proto_err, 1'b0);
`endif
    endtask

    // Send the remaining beats of a block with continuous flow.
    task automatic send_rest(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, rnd128(), 1'b1);
    endtask

    initial begin
        int a0;
        int x0;
        logic [127:0] pt;
        s_valid = 1'b0;
        s_first = 1'b0;
        s_state = '0;
        m_ready = 1'b0;
        acc_cnt  = 0;
        xfer_cnt = 0;
        model_reset();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Constant sequence over an all-zero state.
        for (int i = 0; i <= NR; i++) step(1'b1, (i == 0), 128'h0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Data pass-through and one-cycle latency.
        pt = 128'h0123456789ABCDEF_FEDCBA9876543210;
        step(1'b1, 1'b1, pt, 1'b1);
        check_eq("pt_valid", m_valid, 1'b1);
        check_eq("pt_state", m_state, 128'h012345B3_89ABCDEF_FEDCBA98_76543210);
        send_rest(NR);
        step(1'b0, 1'b0, '0, 1'b1);

        // Backpressure on beat 3.
        for (int i = 0; i < 4; i++) step(1'b1, (i == 0), rnd128(), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 1'b0);
            check_eq("bp_rc", m_rc, 8'h97);
            check_eq("bp_s_ready", s_ready, 1'b0);
        end
        send_rest(NR - 3);
        step(1'b0, 1'b0, '0, 1'b1);

        // Restart mid-block on beat 6.
        for (int i = 0; i < 6; i++) step(1'b1, (i == 0), rnd128(), 1'b1);
        step(1'b1, 1'b1, 128'h0, 1'b1);
        check_eq("restart_rc", m_rc, 8'hD4);
        send_rest(NR);
        step(1'b0, 1'b0, '0, 1'b1);

        // Reset mid-block, taken after beat 9 while the output holds a beat.
        for (int i = 0; i < 10; i++) step(1'b1, (i == 0), rnd128(), 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midreset");
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 128'h0, 1'b1);
        check_eq("postreset_rc", m_rc, 8'hD4);
        send_rest(NR);
        step(1'b0, 1'b0, '0, 1'b1);

        // Two back-to-back blocks.
        a0 = acc_cnt;
        x0 = xfer_cnt;
        for (int i = 0; i < 2 * (NR + 1); i++) step(1'b1, (i % (NR + 1) == 0), rnd128(), 1'b1);
        check_eq("b2b_accepts", 128'(acc_cnt - a0), 128'(2 * (NR + 1)));
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("b2b_xfers", 128'(xfer_cnt - x0), 128'(2 * (NR + 1)));

        // Randomized traffic, with occasional restarts and stalls.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) != 0), ($urandom_range(19) == 0), rnd128(), ($urandom_range(3) != 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
        check_eq("drained", 128'(exp_q.size()), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
